// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: on each VSYNC falling edge, runs an ordered chain of
// game-state update steps through a start/done handshake during vertical
// blanking. Each step has a timeout. Overrun and timeout events are latched in
// sticky flags.
module frame_update_scheduler #(
  parameter int unsigned N_STEPS      = 4,
  parameter int unsigned FRAME_DIV    = 1,
  parameter int unsigned STEP_TIMEOUT = 4096,
  parameter int unsigned FC_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vga_vs,
  input  logic               active,
  input  logic               pause,
  input  logic               clear_err,
  input  logic [N_STEPS-1:0] step_done,
  output logic [N_STEPS-1:0] step_start,
  output logic [N_STEPS-1:0] step_busy,
  output logic               busy,
  output logic               frame_tick,
  output logic [FC_W-1:0]    frame_count,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int unsigned IdxW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned TmrW = $clog2(STEP_TIMEOUT) + 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_STEPS - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(FRAME_DIV - 1);
  localparam logic [TmrW-1:0] LastTmr = TmrW'(STEP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [DivW-1:0] div_cnt_q;
  logic            vs_q;  // vga_vs from the previous cycle
  logic            frame_tick_q;
  logic [FC_W-1:0] frame_count_q;
  logic            overrun_q, timeout_err_q;

  logic fall, launch, tmo_hit, ovr_set;

  assign fall    = vs_q & ~vga_vs;
  assign launch  = fall & ~pause & (div_cnt_q == '0);
  assign busy    = (state_q != StIdle);
  // A frame edge or the visible area reached while a sequence is running.
  assign ovr_set = busy & (fall | active);

  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

  // Frame detection, frame counter and launch divider
  always_ff @(posedge clock) begin
    if (!reset) begin
      vs_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      div_cnt_q     <= '0;
    end else begin
      vs_q         <= vga_vs;
      frame_tick_q <= fall;
      if (fall) begin
        frame_count_q <= frame_count_q + FC_W'(1);
      end
      // The divider keeps counting even when a busy sequence drops the launch.
      if (fall && !pause) begin
        div_cnt_q <= (div_cnt_q == LastDiv) ? '0 : div_cnt_q + DivW'(1);
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Sequencer next state: issue a step, wait for done or timeout, then advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StIssue;
          idx_d   = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        timer_d = '0;
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        if (step_done[idx_q] || (timer_q == LastTmr)) begin
          tmo_hit = ~step_done[idx_q];
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky error flags; a set event in the same cycle as clear_err wins
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      overrun_q     <= ovr_set | (overrun_q & ~clear_err);
      timeout_err_q <= tmo_hit | (timeout_err_q & ~clear_err);
    end
  end

  // One-hot step outputs decoded from the sequencer state
  always_comb begin
    step_start = '0;
    step_busy  = '0;
    if (state_q == StIssue) begin
      step_start[idx_q] = 1'b1;
    end
    if (state_q == StWait) begin
      step_busy[idx_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler. It contains a directed vector table,
// hand-written corner-case sequences and randomized frames. A behavioural
// model, written in terms of step ages, checks two instances every cycle.
module tb_frame_update_scheduler;

  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int FCW_A = 16;
  localparam int FCW_B = 4;

  logic clock = 1'b0;
  logic reset, vga_vs, active, pause, clear_err;
  logic [N-1:0] done_a, done_b;
  logic [N-1:0] start_a, sbusy_a, start_b, sbusy_b;
  logic busy_a, busy_b, tick_a, tick_b, ovr_a, ovr_b, tmo_a, tmo_b;
  logic [FCW_A-1:0] fc_a;
  logic [FCW_B-1:0] fc_b;

  always #5 clock = ~clock;

  frame_update_scheduler #(
    .N_STEPS(N), .FRAME_DIV(1), .STEP_TIMEOUT(TO), .FC_W(FCW_A)
  ) dut_a (
    .clock(clock), .reset(reset), .vga_vs(vga_vs), .active(active), .pause(pause),
    .clear_err(clear_err), .step_done(done_a), .step_start(start_a), .step_busy(sbusy_a),
    .busy(busy_a), .frame_tick(tick_a), .frame_count(fc_a), .overrun(ovr_a),
    .timeout_err(tmo_a)
  );

  frame_update_scheduler #(
    .N_STEPS(N), .FRAME_DIV(3), .STEP_TIMEOUT(TO), .FC_W(FCW_B)
  ) dut_b (
    .clock(clock), .reset(reset), .vga_vs(vga_vs), .active(active), .pause(pause),
    .clear_err(clear_err), .step_done(done_b), .step_start(start_b), .step_busy(sbusy_b),
    .busy(busy_b), .frame_tick(tick_b), .frame_count(fc_b), .overrun(ovr_b),
    .timeout_err(tmo_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model. Per instance: sequence running, current step, and the age
  // of that step (0 = start cycle, 1..TO = waiting).
  bit m_vs [2];
  bit m_seq [2];
  bit m_tick [2];
  bit m_ovr [2];
  bit m_tmo [2];
  int m_step [2];
  int m_age [2];
  int m_count [2];
  int m_div [2];

  // Step-engine responders
  int rem [2];
  int ridx [2];
  int lat [2];
  logic [N-1:0] hold [2];
  bit noise = 1'b0;

  typedef struct {
    logic         vs;
    logic [N-1:0] start;
    logic [N-1:0] sbusy;
    logic         busy;
    logic         tick;
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] d;
      bit fall, set_ovr, set_tmo;
      int div;
      d   = (k == 0) ? done_a : done_b;
      div = (k == 0) ? 1 : 3;
      if (!reset) begin
        m_vs[k] = 1'b1; m_seq[k] = 1'b0; m_step[k] = 0; m_age[k] = 0; m_tick[k] = 1'b0;
        m_count[k] = 0; m_div[k] = 0; m_ovr[k] = 1'b0; m_tmo[k] = 1'b0;
      end else begin
        fall    = m_vs[k] && !vga_vs;
        m_vs[k] = vga_vs;
        set_ovr = m_seq[k] && (fall || active);
        set_tmo = 1'b0;
        if (m_seq[k]) begin
          if (m_age[k] >= 1 && (d[m_step[k]] || m_age[k] == TO)) begin
            set_tmo = !d[m_step[k]];
            if (m_step[k] == N - 1) m_seq[k] = 1'b0;
            else begin
              m_step[k]++;
              m_age[k] = 0;
            end
          end else begin
            m_age[k]++;
          end
        end else if (fall && !pause && m_div[k] == 0) begin
          m_seq[k] = 1'b1; m_step[k] = 0; m_age[k] = 0;
        end
        if (fall && !pause) m_div[k] = (m_div[k] == div - 1) ? 0 : m_div[k] + 1;
        m_tick[k] = fall;
        if (fall) m_count[k]++;
        m_ovr[k] = set_ovr || (m_ovr[k] && !clear_err);
        m_tmo[k] = set_tmo || (m_tmo[k] && !clear_err);
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] es, eb, gs, gb;
      logic gbusy, gtick, govr, gtmo;
      logic [31:0] gfc, ec;
      string p;
      es = '0;
      eb = '0;
      if (m_seq[k]) begin
        if (m_age[k] == 0) es[m_step[k]] = 1'b1;
        else eb[m_step[k]] = 1'b1;
      end
      ec = 32'(m_count[k]) & ((k == 0) ? 32'h0000_FFFF : 32'h0000_000F);
      if (k == 0) begin
        p = "model A"; gs = start_a; gb = sbusy_a; gbusy = busy_a; gtick = tick_a;
        govr = ovr_a; gtmo = tmo_a; gfc = 32'(fc_a);
      end else begin
        p = "model B"; gs = start_b; gb = sbusy_b; gbusy = busy_b; gtick = tick_b;
        govr = ovr_b; gtmo = tmo_b; gfc = 32'(fc_b);
      end
      check({p, " step_start"}, 32'(gs), 32'(es));
      check({p, " step_busy"}, 32'(gb), 32'(eb));
      check({p, " busy"}, 32'(gbusy), 32'(m_seq[k]));
      check({p, " frame_tick"}, 32'(gtick), 32'(m_tick[k]));
      check({p, " frame_count"}, gfc, ec);
      check({p, " overrun"}, 32'(govr), 32'(m_ovr[k]));
      check({p, " timeout_err"}, 32'(gtmo), 32'(m_tmo[k]));
    end
  endtask

  // Drive step_done: pulse done[i] 'lat' cycles after step_start[i] is seen.
  task automatic respond();
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] nd, st;
      nd = '0;
      st = (k == 0) ? start_a : start_b;
      if (rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0 && !hold[k][ridx[k]]) nd[ridx[k]] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (st[i]) begin
          ridx[k] = i;
          rem[k]  = (lat[k] > 0) ? lat[k] : int'($urandom_range(1, 20));
        end
      end
      if (noise && $urandom_range(0, 15) == 0) nd = nd | N'($urandom);
      if (k == 0) done_a = nd;
      else done_b = nd;
    end
  endtask

  task automatic clear_resp();
    rem[0] = 0;
    rem[1] = 0;
    done_a = '0;
    done_b = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    cyc++;
    model_check();
    respond();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; vga_vs = 1'b1; active = 1'b0; pause = 1'b0; clear_err = 1'b0;
    clear_resp();
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while ((busy_a || busy_b) && i < budget) begin
      cycle();
      i++;
    end
    check(name, 32'(busy_a | busy_b), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb1, last_b1, s2, ticks, ns0, fc0, i;
    bit tmo_s2, tmo_before, got_launch, ovr_mid;
    int launch_fr[$];

    // Single frame, each done 3 cycles after its start
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 4'b0000, 4'b0100, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0};

    lat[0] = 3; lat[1] = 3;
    hold[0] = '0; hold[1] = '0;
    do_reset(2);

    check("reset step_start", 32'(start_a), 32'd0);
    check("reset step_busy", 32'(sbusy_a), 32'd0);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset frame_count", 32'(fc_a), 32'd0);
    check("reset overrun", 32'(ovr_a), 32'd0);
    check("reset timeout_err", 32'(tmo_a), 32'd0);

    // Test 1: table-driven basic sequence
    for (int r = 0; r < 19; r++) begin
      vga_vs = tbl[r].vs;
      cycle();
      check($sformatf("t1 row%0d step_start", r), 32'(start_a), 32'(tbl[r].start));
      check($sformatf("t1 row%0d step_busy", r), 32'(sbusy_a), 32'(tbl[r].sbusy));
      check($sformatf("t1 row%0d busy", r), 32'(busy_a), 32'(tbl[r].busy));
      check($sformatf("t1 row%0d frame_tick", r), 32'(tick_a), 32'(tbl[r].tick));
    end
    check("t1 frame_count", 32'(fc_a), 32'd1);
    check("t1 overrun", 32'(ovr_a), 32'd0);
    check("t1 timeout_err", 32'(tmo_a), 32'd0);

    // Test 2: step 1 never completes and must time out after TO busy cycles
    hold[0] = 4'b0010;
    nb1 = 0; last_b1 = -1; s2 = -1; tmo_s2 = 1'b0; tmo_before = 1'b1;
    vga_vs = 1'b0; cycle(); cycle(); vga_vs = 1'b1;
    i = 0;
    while (busy_a && i < 150) begin
      cycle();
      i++;
      if (sbusy_a[1]) begin
        nb1++;
        last_b1 = cyc;
        tmo_before = tmo_a;
      end
      if (start_a[2] && s2 < 0) begin
        s2 = cyc;
        tmo_s2 = tmo_a;
      end
    end
    check("t2 step_busy[1] length", 32'(nb1), 32'(TO));
    check("t2 step_start[2] cycle", 32'(s2), 32'(last_b1 + 1));
    check("t2 timeout_err before expiry", 32'(tmo_before), 32'd0);
    check("t2 timeout_err at next start", 32'(tmo_s2), 32'd1);
    check("t2 sequence finished", 32'(busy_a), 32'd0);
    check("t2 timeout_err sticky", 32'(tmo_a), 32'd1);
    hold[0] = '0;
    wait_idle("t2 idle", 100);

    // Test 3: FRAME_DIV=3 instance over 6 frames
    do_reset(2);
    ticks = 0; ns0 = 0;
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < 30; c++) begin
        vga_vs = (c >= 2);
        cycle();
        if (tick_b) ticks++;
        if (start_b[0]) launch_fr.push_back(ticks);
        if (start_a[0]) ns0++;
      end
    end
    check("t3 frame_tick count", 32'(ticks), 32'd6);
    check("t3 frame_count", 32'(fc_b), 32'd6);
    check("t3 launch count", 32'(launch_fr.size()), 32'd2);
    if (launch_fr.size() == 2) begin
      check("t3 first launch frame", 32'(launch_fr[0]), 32'd1);
      check("t3 second launch frame", 32'(launch_fr[1]), 32'd4);
    end
    check("t3 div1 launches", 32'(ns0), 32'd6);

    // Test 4: pause across two frames, then release
    wait_idle("t4 idle", 100);
    fc0 = int'(fc_a); ticks = 0; ns0 = 0; got_launch = 1'b0;
    pause = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 30; c++) begin
        vga_vs = (c >= 2);
        cycle();
        if (tick_a) ticks++;
        if (start_a != '0) ns0++;
      end
    end
    pause = 1'b0;
    check("t4 paused ticks", 32'(ticks), 32'd2);
    check("t4 paused frame_count", 32'(fc_a), 32'(fc0 + 2));
    check("t4 paused starts", 32'(ns0), 32'd0);
    for (int c = 0; c < 30; c++) begin
      vga_vs = (c >= 2);
      cycle();
      if (tick_a && start_a == 4'b0001) got_launch = 1'b1;
    end
    check("t4 launch after release", 32'(got_launch), 32'd1);

    // Test 5: step 0 withheld past active and the next frame edge
    wait_idle("t5 idle", 100);
    check("t5 overrun baseline", 32'(ovr_a), 32'd0);
    hold[0] = 4'b0001; ns0 = 0; ovr_mid = 1'b0;
    i = 0;
    while ((i < 14 || busy_a) && i < 200) begin
      vga_vs    = !(i < 2 || (i >= 10 && i < 12));
      active    = (i >= 5 && i <= 8);
      clear_err = (i == 6);
      cycle();
      if (start_a[0]) ns0++;
      if (i == 6) ovr_mid = ovr_a;
      i++;
    end
    active = 1'b0; clear_err = 1'b0; vga_vs = 1'b1; hold[0] = '0;
    check("t5 single step_start[0]", 32'(ns0), 32'd1);
    check("t5 set beats clear", 32'(ovr_mid), 32'd1);
    check("t5 overrun", 32'(ovr_a), 32'd1);
    check("t5 timeout_err", 32'(tmo_a), 32'd1);
    wait_idle("t5 idle after", 100);
    clear_err = 1'b1; cycle(); clear_err = 1'b0;
    check("t5 overrun cleared", 32'(ovr_a), 32'd0);
    check("t5 timeout_err cleared", 32'(tmo_a), 32'd0);

    // Test 6: reset while waiting on step 2
    vga_vs = 1'b0; cycle(); cycle(); vga_vs = 1'b1;
    i = 0;
    while (!sbusy_a[2] && i < 100) begin
      cycle();
      i++;
    end
    check("t6 reached step 2", 32'(sbusy_a[2]), 32'd1);
    reset = 1'b0;
    clear_resp();
    cycle();
    reset = 1'b1;
    check("t6 step_busy after reset", 32'(sbusy_a), 32'd0);
    check("t6 step_start after reset", 32'(start_a), 32'd0);
    check("t6 busy after reset", 32'(busy_a), 32'd0);
    check("t6 frame_count after reset", 32'(fc_a), 32'd0);
    cycle(); cycle(); cycle();
    vga_vs = 1'b0; cycle();
    check("t6 restart tick", 32'(tick_a), 32'd1);
    check("t6 restart at step 0", 32'(start_a), 32'd1);
    cycle(); vga_vs = 1'b1;
    check("t6 step 0 busy", 32'(sbusy_a), 32'd1);
    wait_idle("t6 idle", 100);

    // Randomized frames against the model
    do_reset(2);
    noise = 1'b1; lat[0] = 0; lat[1] = 0;
    begin
      int per, pos, act_at;
      per = 60; pos = 0; act_at = 40;
      for (int c = 0; c < 3000; c++) begin
        if (pos == 0) begin
          per    = int'($urandom_range(40, 100));
          act_at = int'($urandom_range(15, per));
          pause  = ($urandom_range(0, 5) == 0);
        end
        vga_vs    = (pos >= 3);
        active    = (pos >= act_at);
        clear_err = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 1499) == 0) begin
          reset = 1'b0;
          clear_resp();
        end else begin
          reset = 1'b1;
        end
        cycle();
        pos = (pos + 1 == per) ? 0 : pos + 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
